mul_n: RTL and testbench
========================

# mul_n

Parameterised unsigned N×N multiplier producing a full-width 2N-bit product. It is a sequential radix-2 shift-add engine with valid/ready handshakes on input and output. It is used wherever a small, area-cheap multiply with a fixed, known latency is acceptable in a clocked datapath.

## Interface

- Clocking: one clock; reset is asynchronous and active-low.
- Parameters:
  - SIZE, default 4: operand width in bits. Legal values are SIZE ≥ 2.
- Ports:
  - clk, input, 1: rising-edge clock.
  - rst_n, input, 1: asynchronous active-low reset.
  - in_valid, input, 1: operands a and b are valid.
  - in_ready, output, 1: engine can accept operands.
  - a, input, SIZE: multiplicand (unsigned).
  - b, input, SIZE: multiplier (unsigned).
  - out_valid, output, 1: y holds a completed product.
  - out_ready, input, 1: consumer accepts y.
  - y, output, 2*SIZE: product a*b (unsigned, registered).

## Operation

- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE: when in_valid=1, the engine captures the operands on that edge:
  - a is zero-extended into a 2*SIZE multiplicand register.
  - b goes into a SIZE-bit multiplier register.
  - The 2*SIZE accumulator is cleared and the step counter is set to 0.
  - State moves to BUSY.
- BUSY performs one step per cycle:
  - If multiplier LSB = 1, accumulator += multiplicand.
  - The multiplicand shifts left by 1 and the multiplier shifts right by 1.
  - The counter increments.
  - There are exactly SIZE steps with no early termination, even for zero operands.
- On the final step the accumulator sum is written into y, and the state moves to DONE.
- DONE: y and out_valid are held until out_ready=1, then the state returns to IDLE.
- Arithmetic:
  - Unsigned throughout. (2^SIZE−1)^2 < 2^(2*SIZE), so no overflow is possible.
  - All internal adds are 2*SIZE bits wide.
- a and b are sampled only at the accept edge. Changes to them while in BUSY or DONE have no effect.
- in_valid while not in IDLE is ignored. No operands are queued.
- y keeps the last product after leaving DONE and updates only on the final BUSY step.

## Timing

- Reset (asynchronous, immediate):
  - state=IDLE, in_ready=1, out_valid=0, y=0.
  - Accumulator, counter and shift registers are 0.
- Reset asserted mid-operation aborts the product; no out_valid pulse follows.
- Accept edge E0 is the rising edge with in_valid & in_ready.
- Latency: out_valid=1 and y valid after edge E0+SIZE (SIZE clocks).
- Output handshake completes on the first edge with out_valid & out_ready. in_ready rises after that edge.
- Minimum issue interval: SIZE+2 cycles (accept, SIZE steps, one DONE cycle). A new accept is possible on the edge after the output handshake.
- out_ready held low stalls the engine in DONE indefinitely, with y stable.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid/out_ready to any output.

## Test plan

- SIZE=4, a=3, b=5, out_ready=1 → out_valid after exactly 4 clocks from accept, y=15. in_ready=0 throughout BUSY/DONE.
- SIZE=4, a=15, b=15 (max) → y=225 (8'b1110_0001). Repeat with SIZE=8, a=b=255 → y=65025.
- a=0, b=9 and a=11, b=0 → y=0, still after exactly SIZE clocks.
- Backpressure: a=7, b=6, out_ready=0 for 10 cycles, then 1 → y=42 stable and out_valid high for all 10 cycles. in_ready returns 1 the cycle after the handshake. Toggling a/b and in_valid during the wait has no effect.
- Reset mid-operation: accept a=9, b=9, pulse rst_n low after 2 steps → immediately in_ready=1, out_valid=0, y=0. Next accept of a=2, b=3 → y=6.
- Random: 20 back-to-back random (a,b) pairs for SIZE=4 with random out_ready stalls → each y equals a*b, in order, each after exactly SIZE clocks.

Source files
------------

// File: rtl/mul_n.sv
// mul_n: sequential radix-2 shift-add unsigned multiplier.
//
// Computes y = a * b (full 2*SIZE-bit product). Each product takes exactly
// SIZE add/shift steps, whatever the operand values.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands a/b are valid
//   in_ready  - engine is idle and can accept operands
//   a, b      - unsigned multiplicand / multiplier (SIZE bits)
//   out_valid - y holds a completed product
//   out_ready - consumer accepts y
//   y         - registered 2*SIZE-bit product; holds the last result
module mul_n #(
  parameter int SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*SIZE-1:0]   y
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST_STEP = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [2*SIZE-1:0] mcand;
  logic [SIZE-1:0]   mplier;
  logic [2*SIZE-1:0] acc;
  logic [CW-1:0]     count;
  logic [2*SIZE-1:0] sum;
  logic              last_step;

  // The step's sum is shared by the accumulator update and the final write
  // into y, so the product lands in y on the last BUSY edge, not one later.
  assign sum       = acc + (mplier[0] ? mcand : '0);
  assign last_step = (state == BUSY) && (count == LAST_STEP);

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)  next_state = BUSY;
      BUSY: if (last_step) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift-add step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{SIZE{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_step) begin
            y <= sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_n.sv
// tb_mul_n: self-checking bench for mul_n.
//
// Drives a SIZE=4 instance through directed and random transactions and a
// SIZE=8 instance through a few full-width products. Expected products come
// from plain integer multiplication of the applied operands.
module tb_mul_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] y8;

  int vec_count = 0;
  int err_count = 0;

  mul_n #(.SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y)
  );

  mul_n #(.SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One full SIZE=4 transaction: accept, count latency, hold out_ready low
  // for 'stall' cycles while scrambling inputs, then complete the handshake.
  task automatic applyStimulus(input logic [3:0] op_a, input logic [3:0] op_b,
                               input int stall);
    int cycles;
    logic [7:0] expected;
    expected = 8'(int'(op_a) * int'(op_b));

    cycles = 0;
    while (!in_ready && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);

    a         = op_a;
    b         = op_b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;

    cycles = 0;
    while (!out_valid && cycles < 16) begin
      checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'd4);
    checkOutput("out_valid_done", 32'(out_valid), 32'd1);
    checkOutput("product", 32'(y), 32'(expected));
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);

    for (int i = 0; i < stall; i++) begin
      a        = 4'($urandom);
      b        = 4'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_y", 32'(y), 32'(expected));
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("post_hs_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_hs_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_hs_y_held", 32'(y), 32'(expected));
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int cycles;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] expected8;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    a8         = '0;
    b8         = '0;

    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_y", 32'(y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed SIZE=4 cases, including zero operands and backpressure.
    applyStimulus(4'd3, 4'd5, 0);
    applyStimulus(4'd15, 4'd15, 0);
    applyStimulus(4'd0, 4'd9, 0);
    applyStimulus(4'd11, 4'd0, 1);
    applyStimulus(4'd7, 4'd6, 10);

    // Abort a product two steps in; y still holds 42 so the clear is visible.
    a        = 4'd9;
    b        = 4'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_y", 32'(y), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(4'd2, 4'd3, 0);

    // Back-to-back random pairs with random consumer stalls.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    // SIZE=8: full-scale product plus a few random pairs; out_ready8 stays high.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        ra = 8'd255;
        rb = 8'd255;
      end else begin
        ra = 8'($urandom);
        rb = 8'($urandom);
      end
      expected8 = 16'(int'(ra) * int'(rb));
      checkOutput("s8_in_ready", 32'(in_ready8), 32'd1);
      a8        = ra;
      b8        = rb;
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      cycles = 0;
      while (!out_valid8 && cycles < 30) begin
        @(posedge clk); #1;
        cycles++;
      end
      checkOutput("s8_latency", 32'(cycles), 32'd8);
      checkOutput("s8_product", 32'(y8), 32'(expected8));
      @(posedge clk); #1;
      checkOutput("s8_post_hs_out_valid", 32'(out_valid8), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
